// File: rtl/mc_controller.sv
// Multi-cycle RISC-V main controller: Moore FSM plus ALU and immediate decode.
// Drives the shared-memory datapath for lw, sw, R, I-ALU, beq and jal.
module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       illegal,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     state;
    state_t     state_nx;
    logic       is_lw;
    logic       is_sw;
    logic       is_r;
    logic       is_i;
    logic       is_beq;
    logic       is_jal;
    logic       is_legal;
    logic       branch;
    logic       pc_update;
    logic [1:0] alu_op;

    assign is_lw    = (op == OP_LW);
    assign is_sw    = (op == OP_SW);
    assign is_r     = (op == OP_R);
    assign is_i     = (op == OP_I);
    assign is_beq   = (op == OP_BEQ);
    assign is_jal   = (op == OP_JAL);
    assign is_legal = is_lw | is_sw | is_r | is_i | is_beq | is_jal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (is_lw | is_sw): state_nx = S_MEMADR;
                    is_r:            state_nx = S_EXECR;
                    is_i:            state_nx = S_EXECI;
                    is_beq:          state_nx = S_BEQ;
                    is_jal:          state_nx = S_JAL;
                    default:         state_nx = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nx = is_lw ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_nx = S_FETCH;
            S_EXECR,
            S_EXECI:    state_nx = S_ALUWB;
            default:    state_nx = S_FETCH;
        endcase
    end

    // Fetch strobes are masked by reset so a held-high mem_ready cannot load IR.
    always_comb begin
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        branch     = 1'b0;
        pc_update  = 1'b0;
        unique case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready & reset_n;
                pc_update  = mem_ready & reset_n;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal   = ~is_legal;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write = pc_update | (branch & zero);

    always_comb begin
        imm_src = 2'b00;
        unique case (1'b1)
            is_sw:   imm_src = 2'b01;
            is_beq:  imm_src = 2'b10;
            is_jal:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        unique case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                unique case (funct3)
                    3'b000:  alu_control = (is_r & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: decode table, hand sequences, random run
// against a queue-of-steps instruction model.
module tb_mc_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int K_FETCH = 0;
    localparam int K_DEC   = 1;
    localparam int K_ADR   = 2;
    localparam int K_RD    = 3;
    localparam int K_WB    = 4;
    localparam int K_WR    = 5;
    localparam int K_EXR   = 6;
    localparam int K_EXI   = 7;
    localparam int K_AWB   = 8;
    localparam int K_BEQ   = 9;
    localparam int K_JAL   = 10;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic [2:0] exp_alu;
        logic [1:0] exp_imm;
        logic       exp_pcw;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   steps[$];
    out_t last;

    mc_controller dut (
        .clk(clk),
        .reset_n(reset_n),
        .op(op),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .zero(zero),
        .mem_ready(mem_ready),
        .pc_write(pc_write),
        .adr_src(adr_src),
        .mem_write(mem_write),
        .ir_write(ir_write),
        .reg_write(reg_write),
        .illegal(illegal),
        .result_src(result_src),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .imm_src(imm_src),
        .alu_control(alu_control)
    );

    always #5 clk = ~clk;

    function automatic out_t got_now();
        return {pc_write, adr_src, mem_write, ir_write, reg_write, illegal,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control};
    endfunction

    function automatic logic legal(logic [6:0] o);
        return o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
               o == OP_BEQ || o == OP_JAL;
    endfunction

    function automatic logic [2:0] arith(logic [6:0] o, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (o == OP_R && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic out_t model(int k, logic [6:0] o, logic [2:0] f3,
                                   logic f7, logic z, logic mr, logic rst);
        out_t e = '0;
        if (o == OP_SW)       e.imm_src = 2'b01;
        else if (o == OP_BEQ) e.imm_src = 2'b10;
        else if (o == OP_JAL) e.imm_src = 2'b11;
        case (k)
            K_FETCH: begin
                e.alu_src_b  = 2'b10;
                e.result_src = 2'b10;
                e.ir_write   = mr & ~rst;
                e.pc_write   = mr & ~rst;
            end
            K_DEC: begin
                e.alu_src_a = 2'b01;
                e.alu_src_b = 2'b01;
                e.illegal   = ~legal(o);
            end
            K_ADR: begin
                e.alu_src_a = 2'b10;
                e.alu_src_b = 2'b01;
            end
            K_RD: e.adr_src = 1'b1;
            K_WB: begin
                e.result_src = 2'b01;
                e.reg_write  = 1'b1;
            end
            K_WR: begin
                e.adr_src   = 1'b1;
                e.mem_write = 1'b1;
            end
            K_EXR, K_EXI: begin
                e.alu_src_a   = 2'b10;
                e.alu_src_b   = (k == K_EXI) ? 2'b01 : 2'b00;
                e.alu_control = arith(o, f3, f7);
            end
            K_AWB: e.reg_write = 1'b1;
            K_BEQ: begin
                e.alu_src_a   = 2'b10;
                e.alu_control = 3'b001;
                e.pc_write    = z;
            end
            K_JAL: begin
                e.alu_src_a = 2'b01;
                e.alu_src_b = 2'b10;
                e.pc_write  = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int cur();
        return (steps.size() == 0) ? K_FETCH : steps[0];
    endfunction

    // An instruction is the list of steps left after its fetch completes.
    task automatic advance();
        int k = cur();
        if (k == K_FETCH) begin
            if (mem_ready) begin
                steps.push_back(K_DEC);
                case (op)
                    OP_LW:  begin steps.push_back(K_ADR); steps.push_back(K_RD);
                                  steps.push_back(K_WB); end
                    OP_SW:  begin steps.push_back(K_ADR); steps.push_back(K_WR); end
                    OP_R:   begin steps.push_back(K_EXR); steps.push_back(K_AWB); end
                    OP_I:   begin steps.push_back(K_EXI); steps.push_back(K_AWB); end
                    OP_BEQ: steps.push_back(K_BEQ);
                    OP_JAL: steps.push_back(K_JAL);
                    default: ;
                endcase
            end
        end else if (!((k == K_RD || k == K_WR) && !mem_ready)) begin
            void'(steps.pop_front());
        end
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(string name);
        out_t e;
        #1;
        e = model(cur(), op, funct3, funct7b5, zero, mem_ready, 1'b0);
        last = got_now();
        check(name, 32'(last), 32'(e));
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        #2;
        check("reset_outs", 32'(got_now()),
              32'(model(K_FETCH, op, funct3, funct7b5, zero, 1'b1, 1'b1)));
        @(posedge clk);
        #1;
        check("reset_hold", 32'(got_now()),
              32'(model(K_FETCH, op, funct3, funct7b5, zero, 1'b1, 1'b1)));
        @(negedge clk);
        mem_ready = 1'b0;
        reset_n   = 1'b1;
        steps.delete();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[12];
    int   cnt;
    int   at;

    initial begin
        vt[0]  = '{OP_R,   3'b000, 1'b1, 1'b0, 3'b001, 2'b00, 1'b0};
        vt[1]  = '{OP_I,   3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 1'b0};
        vt[2]  = '{OP_R,   3'b111, 1'b0, 1'b0, 3'b010, 2'b00, 1'b0};
        vt[3]  = '{OP_I,   3'b110, 1'b0, 1'b0, 3'b011, 2'b00, 1'b0};
        vt[4]  = '{OP_R,   3'b010, 1'b1, 1'b0, 3'b101, 2'b00, 1'b0};
        vt[5]  = '{OP_R,   3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0};
        vt[6]  = '{OP_R,   3'b001, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0};
        vt[7]  = '{OP_BEQ, 3'b111, 1'b0, 1'b1, 3'b001, 2'b10, 1'b1};
        vt[8]  = '{OP_BEQ, 3'b111, 1'b0, 1'b0, 3'b001, 2'b10, 1'b0};
        vt[9]  = '{OP_JAL, 3'b010, 1'b0, 1'b0, 3'b000, 2'b11, 1'b1};
        vt[10] = '{OP_SW,  3'b010, 1'b0, 1'b0, 3'b000, 2'b01, 1'b0};
        vt[11] = '{OP_LW,  3'b010, 1'b0, 1'b0, 3'b000, 2'b00, 1'b0};

        op = OP_LW;
        do_reset();

        // Third cycle after reset is EXECR/EXECI/BEQ/JAL/MEMADR.
        foreach (vt[i]) begin
            do_reset();
            op = vt[i].op; funct3 = vt[i].f3; funct7b5 = vt[i].f7;
            zero = vt[i].z; mem_ready = 1'b1;
            tick("tbl_fetch");
            tick("tbl_decode");
            #1;
            check($sformatf("tbl%0d_alu", i), 32'(alu_control), 32'(vt[i].exp_alu));
            check($sformatf("tbl%0d_imm", i), 32'(imm_src), 32'(vt[i].exp_imm));
            check($sformatf("tbl%0d_pcw", i), 32'(pc_write), 32'(vt[i].exp_pcw));
            tick("tbl_exec");
        end

        // lw, no stalls: reg_write only in the fifth cycle
        do_reset();
        op = OP_LW; mem_ready = 1'b1; cnt = 0; at = -1;
        for (int c = 0; c < 5; c++) begin
            tick("lw_seq");
            if (last.reg_write) begin cnt++; at = c; end
            if (c == 4) check("lw_res_src", 32'(last.result_src), 32'd1);
            check("lw_imm", 32'(last.imm_src), 32'd0);
        end
        check("lw_rw_count", 32'(cnt), 32'd1);
        check("lw_rw_cycle", 32'(at), 32'd4);
        mem_ready = 1'b0;
        tick("lw_back");
        check("lw_back_fetch", 32'(last.result_src), 32'd2);

        // sw with two stall cycles in MEMWRITE
        do_reset();
        op = OP_SW; mem_ready = 1'b1; cnt = 0;
        for (int c = 0; c < 6; c++) begin
            mem_ready = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            tick("sw_seq");
            if (last.mem_write) cnt++;
        end
        check("sw_imm", 32'(last.imm_src), 32'd1);
        check("sw_mw_count", 32'(cnt), 32'd3);
        mem_ready = 1'b0;
        tick("sw_back");
        check("sw_back_mw", 32'(last.mem_write), 32'd0);
        check("sw_back_fetch", 32'(last.result_src), 32'd2);

        // fetch stalled three cycles
        do_reset();
        op = OP_R; mem_ready = 1'b0; cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick("fst_seq");
            cnt += int'(last.ir_write) + int'(last.pc_write);
        end
        check("fst_stall_strobes", 32'(cnt), 32'd0);
        mem_ready = 1'b1;
        tick("fst_go");
        check("fst_irw", 32'(last.ir_write), 32'd1);
        check("fst_pcw", 32'(last.pc_write), 32'd1);
        tick("fst_decode");
        check("fst_decode_a", 32'(last.alu_src_a), 32'd1);

        // illegal opcode
        do_reset();
        op = 7'b0000000; mem_ready = 1'b1; cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) mem_ready = 1'b0;
            tick("ill_seq");
            if (last.illegal) cnt++;
        end
        check("ill_count", 32'(cnt), 32'd1);
        check("ill_back_fetch", 32'(last.result_src), 32'd2);

        // reset while stalled in MEMREAD
        do_reset();
        op = OP_LW; mem_ready = 1'b1;
        tick("rst_f"); tick("rst_d"); tick("rst_a");
        mem_ready = 1'b0;
        tick("rst_rd");
        #1;
        check("rst_in_rd_adr", 32'(adr_src), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_async_fetch", 32'(result_src), 32'd2);
        check("rst_async_mwrw", 32'({mem_write, reg_write}), 32'd0);
        do_reset();

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if (cur() == K_FETCH) begin
                case ($urandom_range(0, 6))
                    0: op = OP_LW;
                    1: op = OP_SW;
                    2: op = OP_R;
                    3: op = OP_I;
                    4: op = OP_BEQ;
                    5: op = OP_JAL;
                    default: op = 7'($urandom);
                endcase
            end
            funct3    = 3'($urandom);
            funct7b5  = 1'($urandom);
            zero      = 1'($urandom);
            mem_ready = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
